// File: rtl/exec_step_controller.sv
// Purpose: sequences the single-cycle CPU (step, divided free-run, PC breakpoint, self-loop halt, reset stretch).
// Latency: cpu_en rises the cycle after a step request; in RUN it pulses once every RUN_DIV cycles.
// Backpressure: none; request pulses are sampled every cycle, priority rst_req > run_toggle > step_req.
// Optional: define EXEC_MEMWRITE_BREAK_EN to halt RUN on any retired store (cause 2'b11).
module exec_step_controller #(
    parameter int unsigned RUN_DIV    = 4,
    parameter int unsigned RST_CYCLES = 4,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             step_req,
    input  logic             run_toggle,
    input  logic             rst_req,
    input  logic [31:0]      pc,
    input  logic             memwrite,
    input  logic [31:0]      bp_pc,
    input  logic             bp_valid,
    output logic             cpu_en,
    output logic             cpu_rst,
    output logic             running,
    output logic             halted,
    output logic [1:0]       halt_cause,
    output logic [CNT_W-1:0] instr_count
);

    localparam int unsigned DIV_W = $clog2(RUN_DIV);
    localparam int unsigned RC_W  = $clog2(RST_CYCLES + 1);

    localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(RUN_DIV - 1);
    localparam logic [RC_W-1:0]  RST_RELOAD = RC_W'(RST_CYCLES - 1);

    localparam logic [1:0] CAUSE_NONE = 2'b00;
    localparam logic [1:0] CAUSE_BP   = 2'b01;
    localparam logic [1:0] CAUSE_LOOP = 2'b10;
`ifdef EXEC_MEMWRITE_BREAK_EN
    localparam logic [1:0] CAUSE_MW   = 2'b11;
`endif

    typedef enum logic [2:0] {
        ST_RSTSEQ,
        ST_PAUSED,
        ST_STEP,
        ST_RUN,
        ST_HALT
    } state_t;

    state_t            state_q, state_d;
    logic              cpu_en_q, cpu_en_d;
    logic              cpu_rst_q, cpu_rst_d;
    logic              running_q, running_d;
    logic              halted_q, halted_d;
    logic [1:0]        cause_q, cause_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [RC_W-1:0]   rst_cnt_q, rst_cnt_d;
    logic              chk_q, chk_d;
    logic [31:0]       pc_prev_q, pc_prev_d;
`ifdef EXEC_MEMWRITE_BREAK_EN
    logic              mw_q, mw_d;
`else
    logic              unused_memwrite;
    assign unused_memwrite = memwrite;
`endif

    logic              halt_hit;
    logic [1:0]        halt_code;
    logic [CNT_W-1:0]  cnt_inc;

    // Halt condition on the pc the processor moved to after the last retired instruction.
    always_comb begin
        halt_hit  = 1'b0;
        halt_code = CAUSE_NONE;
        if (bp_valid && (pc == bp_pc)) begin
            halt_hit  = 1'b1;
            halt_code = CAUSE_BP;
        end else if (pc == pc_prev_q) begin
            halt_hit  = 1'b1;
            halt_code = CAUSE_LOOP;
        end
`ifdef EXEC_MEMWRITE_BREAK_EN
        else if (mw_q) begin
            halt_hit  = 1'b1;
            halt_code = CAUSE_MW;
        end
`endif
    end

    // Saturating increment of the retired-instruction counter.
    always_comb begin
        cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
    end

    // Next-state and next-output logic for the sequencer.
    always_comb begin
        state_d   = state_q;
        cpu_en_d  = 1'b0;
        cpu_rst_d = 1'b0;
        cause_d   = cause_q;
        div_d     = div_q;
        rst_cnt_d = rst_cnt_q;
        // Halt checks look at the cycle right after an enable pulse.
        chk_d     = cpu_en_q;
        pc_prev_d = cpu_en_q ? pc : pc_prev_q;
`ifdef EXEC_MEMWRITE_BREAK_EN
        mw_d      = cpu_en_q ? memwrite : mw_q;
`endif
        cnt_d     = cpu_en_q ? cnt_inc : cnt_q;

        if (rst_req) begin
            // Restart the full reset stretch; any enable that would fire next cycle is dropped.
            state_d   = ST_RSTSEQ;
            cpu_rst_d = 1'b1;
            rst_cnt_d = RST_RELOAD;
            cnt_d     = '0;
            cause_d   = CAUSE_NONE;
            div_d     = DIV_RELOAD;
        end else begin
            case (state_q)
                ST_RSTSEQ: begin
                    cnt_d = '0;
                    if (rst_cnt_q == '0) begin
                        state_d = ST_PAUSED;
                    end else begin
                        cpu_rst_d = 1'b1;
                        rst_cnt_d = rst_cnt_q - RC_W'(1);
                    end
                end
                ST_PAUSED: begin
                    if (run_toggle) begin
                        state_d = ST_RUN;
                        div_d   = DIV_RELOAD;
                    end else if (step_req) begin
                        state_d  = ST_STEP;
                        cpu_en_d = 1'b1;
                    end
                end
                ST_STEP: begin
                    // The enable pulse is on the output during this cycle.
                    state_d = ST_PAUSED;
                end
                ST_RUN: begin
                    if (run_toggle) begin
                        state_d = ST_PAUSED;
                    end else if (chk_q && halt_hit) begin
                        // Halting wins over an enable that the divider would issue now.
                        state_d = ST_HALT;
                        cause_d = halt_code;
                    end else if (div_q == '0) begin
                        cpu_en_d = 1'b1;
                        div_d    = DIV_RELOAD;
                    end else begin
                        div_d = div_q - DIV_W'(1);
                    end
                end
                ST_HALT: begin
                    if (run_toggle) begin
                        state_d = ST_RUN;
                        div_d   = DIV_RELOAD;
                        cause_d = CAUSE_NONE;
                    end else if (step_req) begin
                        state_d  = ST_STEP;
                        cpu_en_d = 1'b1;
                        cause_d  = CAUSE_NONE;
                    end
                end
                default: begin
                    state_d   = ST_RSTSEQ;
                    cpu_rst_d = 1'b1;
                    rst_cnt_d = RST_RELOAD;
                end
            endcase
        end

        running_d = (state_d == ST_RUN);
        halted_d  = (state_d == ST_HALT);
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_RSTSEQ;
        end else begin
            state_q <= state_d;
        end
    end

    // Registered outputs and datapath bookkeeping.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cpu_en_q  <= 1'b0;
            cpu_rst_q <= 1'b1;
            running_q <= 1'b0;
            halted_q  <= 1'b0;
            cause_q   <= CAUSE_NONE;
            cnt_q     <= '0;
            div_q     <= DIV_RELOAD;
            rst_cnt_q <= RST_RELOAD;
            chk_q     <= 1'b0;
            pc_prev_q <= '0;
`ifdef EXEC_MEMWRITE_BREAK_EN
            mw_q      <= 1'b0;
`endif
        end else begin
            cpu_en_q  <= cpu_en_d;
            cpu_rst_q <= cpu_rst_d;
            running_q <= running_d;
            halted_q  <= halted_d;
            cause_q   <= cause_d;
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            rst_cnt_q <= rst_cnt_d;
            chk_q     <= chk_d;
            pc_prev_q <= pc_prev_d;
`ifdef EXEC_MEMWRITE_BREAK_EN
            mw_q      <= mw_d;
`endif
        end
    end

    assign cpu_en      = cpu_en_q;
    assign cpu_rst     = cpu_rst_q;
    assign running     = running_q;
    assign halted      = halted_q;
    assign halt_cause  = cause_q;
    assign instr_count = cnt_q;

endmodule

// File: tb/tb_exec_step_controller.sv
// Bench for exec_step_controller: directed scenarios plus random pulses,
// checked every cycle against a timestamp-based model of the sequencer.
// A narrow counter width is used so saturation is reachable.
module tb_exec_step_controller;

    localparam int RUN_DIV    = 4;
    localparam int RST_CYCLES = 4;
    localparam int CNT_W      = 4;
    localparam int CNT_MAX    = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset;
    logic             step_req, run_toggle, rst_req;
    logic [31:0]      pc;
    logic             memwrite;
    logic [31:0]      bp_pc;
    logic             bp_valid;
    logic             cpu_en, cpu_rst, running, halted;
    logic [1:0]       halt_cause;
    logic [CNT_W-1:0] instr_count;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    exec_step_controller #(
        .RUN_DIV    (RUN_DIV),
        .RST_CYCLES (RST_CYCLES),
        .CNT_W      (CNT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .step_req    (step_req),
        .run_toggle  (run_toggle),
        .rst_req     (rst_req),
        .pc          (pc),
        .memwrite    (memwrite),
        .bp_pc       (bp_pc),
        .bp_valid    (bp_valid),
        .cpu_en      (cpu_en),
        .cpu_rst     (cpu_rst),
        .running     (running),
        .halted      (halted),
        .halt_cause  (halt_cause),
        .instr_count (instr_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- processor model: pc advances at the edge ending an enable cycle
    logic        en_seen  = 1'b0;
    logic        rst_seen = 1'b1;
    logic [31:0] hold_at  = 32'hFFFF_FFFF;
    bit          mw_arm   = 1'b0;
    bit          mw_rand  = 1'b0;

    initial begin
        pc       = 32'h0;
        memwrite = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rst_seen)     pc = 32'h0;
            else if (en_seen) pc = (pc == hold_at) ? pc : pc + 32'd4;
            if (mw_rand) memwrite = ($urandom_range(0, 3) == 0);
            else         memwrite = mw_arm && (pc == 32'h4);
        end
    end

    // ---------------- behavioural model: modes with entry timestamps
    localparam int M_RST = 0, M_PAUSE = 1, M_STEP = 2, M_RUN = 3, M_HALT = 4;
    int          cyc = 0;
    int          m_mode = M_RST;
    int          m_since = 1;
    int          m_cnt = 0;
    int          m_cause = 0;
    logic [31:0] m_prev = 32'h0;
    bit          m_chk = 1'b0;
`ifdef EXEC_MEMWRITE_BREAK_EN
    bit          m_mw = 1'b0;
`endif

    always @(negedge clk) begin
        bit e_en;
        bit chk_now;
        int hc;
        en_seen  = cpu_en;
        rst_seen = cpu_rst;
        if (!reset) begin
            m_mode  = M_RST;
            m_since = cyc + 1;
            m_cnt   = 0;
            m_cause = 0;
            m_prev  = 32'h0;
            m_chk   = 1'b0;
`ifdef EXEC_MEMWRITE_BREAK_EN
            m_mw    = 1'b0;
`endif
        end
        // An instruction issues in STEP, and in RUN once every RUN_DIV cycles after entry.
        e_en = (m_mode == M_STEP) ||
               (m_mode == M_RUN && cyc > m_since && ((cyc - m_since) % RUN_DIV) == 0);
        check("cyc_cpu_en",   32'(cpu_en),      32'(e_en));
        check("cyc_cpu_rst",  32'(cpu_rst),     32'(m_mode == M_RST));
        check("cyc_running",  32'(running),     32'(m_mode == M_RUN));
        check("cyc_halted",   32'(halted),      32'(m_mode == M_HALT));
        check("cyc_cause",    32'(halt_cause),  32'(m_cause));
        check("cyc_count",    32'(instr_count), 32'(m_cnt));
        if (reset) begin
            chk_now = m_chk;
            m_chk   = e_en;
            hc = 0;
            if (bp_valid && pc == bp_pc) hc = 1;
            else if (pc == m_prev)       hc = 2;
`ifdef EXEC_MEMWRITE_BREAK_EN
            else if (m_mw)               hc = 3;
`endif
            if (e_en) begin
                if (m_cnt < CNT_MAX) m_cnt++;
                m_prev = pc;
`ifdef EXEC_MEMWRITE_BREAK_EN
                m_mw   = memwrite;
`endif
            end
            if (rst_req) begin
                m_mode  = M_RST;
                m_since = cyc + 1;
                m_cnt   = 0;
                m_cause = 0;
            end else begin
                case (m_mode)
                    M_RST: begin
                        m_cnt = 0;
                        if (cyc - m_since == RST_CYCLES - 1) m_mode = M_PAUSE;
                    end
                    M_PAUSE: begin
                        if (run_toggle) begin
                            m_mode = M_RUN; m_since = cyc + 1;
                        end else if (step_req) begin
                            m_mode = M_STEP;
                        end
                    end
                    M_STEP: m_mode = M_PAUSE;
                    M_RUN: begin
                        if (run_toggle) m_mode = M_PAUSE;
                        else if (chk_now && hc != 0) begin
                            m_mode = M_HALT; m_cause = hc;
                        end
                    end
                    M_HALT: begin
                        if (run_toggle) begin
                            m_mode = M_RUN; m_since = cyc + 1; m_cause = 0;
                        end else if (step_req) begin
                            m_mode = M_STEP; m_cause = 0;
                        end
                    end
                    default: m_mode = M_RST;
                endcase
            end
        end
        cyc++;
    end

    // ---------------- stimulus helpers
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input bit s, input bit t, input bit r);
        next_cycle();
        step_req = s; run_toggle = t; rst_req = r;
        next_cycle();
        step_req = 1'b0; run_toggle = 1'b0; rst_req = 1'b0;
    endtask

    task automatic do_reset();
        pulse(1'b0, 1'b0, 1'b1);
        repeat (RST_CYCLES + 1) next_cycle();
    endtask

    task automatic wait_halt(input int max, input string name);
        int n = 0;
        while (!halted && n < max) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!halted) begin
            errors++;
            $display("FAIL %s: no halt within %0d cycles, halted=%0b required 1", name, max, halted);
        end
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached, finished=0 required 1");
        $fatal(1);
    end

    initial begin
        int rst_hi, en_hi, extra;
        reset = 1'b0; step_req = 1'b0; run_toggle = 1'b0; rst_req = 1'b0;
        bp_pc = 32'h0; bp_valid = 1'b0;

        // Reset state and stretch length after release.
        repeat (3) next_cycle();
        check("reset_cpu_rst", 32'(cpu_rst), 32'd1);
        check("reset_cpu_en",  32'(cpu_en),  32'd0);
        check("reset_count",   32'(instr_count), 32'd0);
        reset = 1'b1;
        rst_hi = 0; en_hi = 0;
        repeat (8) begin
            @(negedge clk);
            rst_hi += int'(cpu_rst);
            en_hi  += int'(cpu_en);
        end
        check("rstseq_len",    32'(rst_hi), 32'(RST_CYCLES));
        check("rstseq_no_en",  32'(en_hi),  32'd0);
        check("paused_count",  32'(instr_count), 32'd0);
        check("paused_running", 32'(running), 32'd0);

        // Three single steps, ten cycles apart.
        extra = 0;
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            step_req = 1'b1;
            @(negedge clk);
            check("step_en_early", 32'(cpu_en), 32'd0);
            next_cycle();
            step_req = 1'b0;
            @(negedge clk);
            check("step_en_pulse", 32'(cpu_en), 32'd1);
            repeat (8) begin
                @(negedge clk);
                extra += int'(cpu_en);
            end
        end
        check("step_extra_en", 32'(extra), 32'd0);
        check("step_count",    32'(instr_count), 32'd3);
        check("step_running",  32'(running), 32'd0);

        // Free-run into a breakpoint at 0xC.
        do_reset();
        bp_pc = 32'h0000_000C; bp_valid = 1'b1;
        pulse(1'b0, 1'b1, 1'b0);
        wait_halt(60, "bp_wait");
        check("bp_cause", 32'(halt_cause), 32'd1);
        check("bp_count", 32'(instr_count), 32'd3);
        check("bp_pc",    pc, 32'h0000_000C);
        check("bp_model_count", 32'(m_cnt), 32'd3);

        // Self-loop at 0x20, then resume and loop again.
        do_reset();
        bp_valid = 1'b0; hold_at = 32'h0000_0020;
        pulse(1'b0, 1'b1, 1'b0);
        wait_halt(100, "loop_wait");
        check("loop_cause", 32'(halt_cause), 32'd2);
        check("loop_count", 32'(instr_count), 32'd9);
        pulse(1'b0, 1'b1, 1'b0);
        wait_halt(20, "loop_resume_wait");
        check("loop2_cause", 32'(halt_cause), 32'd2);
        check("loop2_count", 32'(instr_count), 32'd10);
        hold_at = 32'hFFFF_FFFF;

        // All three requests at once while an enable is about to issue.
        do_reset();
        pulse(1'b0, 1'b1, 1'b0);
        repeat (RUN_DIV + 3) next_cycle();
        step_req = 1'b1; run_toggle = 1'b1; rst_req = 1'b1;
        next_cycle();
        step_req = 1'b0; run_toggle = 1'b0; rst_req = 1'b0;
        rst_hi = 0; en_hi = 0;
        repeat (RST_CYCLES) begin
            @(negedge clk);
            rst_hi += int'(cpu_rst);
            en_hi  += int'(cpu_en);
        end
        check("prio_no_en",  32'(en_hi),  32'd0);
        check("prio_rst_len", 32'(rst_hi), 32'(RST_CYCLES));
        @(negedge clk);
        check("prio_rst_done", 32'(cpu_rst), 32'd0);
        check("prio_running",  32'(running), 32'd0);
        check("prio_count",    32'(instr_count), 32'd0);

        // Store on the second instruction.
        do_reset();
        mw_arm = 1'b1;
        pulse(1'b0, 1'b1, 1'b0);
`ifdef EXEC_MEMWRITE_BREAK_EN
        wait_halt(40, "mw_wait");
        check("mw_cause", 32'(halt_cause), 32'd3);
        check("mw_count", 32'(instr_count), 32'd2);
`else
        repeat (30) next_cycle();
        check("mw_still_running", 32'(running), 32'd1);
        check("mw_not_halted",    32'(halted),  32'd0);
        pulse(1'b0, 1'b1, 1'b0);
`endif
        mw_arm = 1'b0;

        // Counter saturation.
        do_reset();
        for (int i = 0; i < CNT_MAX + 5; i++) begin
            pulse(1'b1, 1'b0, 1'b0);
            next_cycle();
        end
        check("sat_count", 32'(instr_count), 32'(CNT_MAX));

        // Random pulses, breakpoints, loops and stores.
        mw_rand = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            next_cycle();
            rst_req    = ($urandom_range(0, 199) == 0);
            run_toggle = ($urandom_range(0, 29) == 0);
            step_req   = ($urandom_range(0, 14) == 0);
            if ($urandom_range(0, 49) == 0) begin
                bp_pc    = 32'($urandom_range(0, 16)) * 32'd4;
                bp_valid = 1'($urandom_range(0, 1));
                hold_at  = 32'($urandom_range(0, 20)) * 32'd4;
            end
        end
        step_req = 1'b0; run_toggle = 1'b0; rst_req = 1'b0;
        repeat (10) next_cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/exec_step_controller.md
Name: exec_step_controller

Overview:
- Sequences the single-cycle processor on the board.
- Produces a one-cycle clock enable and a stretched reset for the datapath, all from the free-running board clk.
- Supports single-step, free-run at a divided rate, PC breakpoint and self-loop halt.
- Sits between the debounced button pulses and the top module; its status outputs feed the display controller.

Parameters:
- RUN_DIV, 4, clk cycles between instructions in RUN mode. Minimum 2; board build overrides to 25_000_000.
- RST_CYCLES, 4, number of cycles cpu_rst is held high per reset sequence. Minimum 1.
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  board clock; the only clock.
- reset  in  1  asynchronous, active-low block reset.
- step_req  in  1  one-cycle debounced pulse: execute one instruction.
- run_toggle  in  1  one-cycle pulse: start or stop free-run.
- rst_req  in  1  one-cycle pulse: reset the processor.
- pc  in  32  current processor PC.
- memwrite  in  1  processor memwrite for the current instruction.
- bp_pc  in  32  breakpoint address.
- bp_valid  in  1  breakpoint enable.
- cpu_en  out  1  registered clock enable to the processor, high for exactly 1 cycle per instruction.
- cpu_rst  out  1  registered active-high processor reset.
- running  out  1  high in RUN.
- halted  out  1  high in HALT.
- halt_cause  out  2  00 none, 01 breakpoint, 10 self-loop, 11 memwrite (optional feature).
- instr_count  out  CNT_W  retired instructions, saturating.

Behaviour:
- States: RSTSEQ, PAUSED, STEP, RUN, HALT.
- Async reset (reset=0), values on reset:
  - state=RSTSEQ, cpu_rst=1, cpu_en=0, running=0, halted=0, halt_cause=00, instr_count=0, divider=RUN_DIV-1.
- RSTSEQ:
  - cpu_rst held high for RST_CYCLES cycles; instr_count cleared.
  - Then cpu_rst=0 and the block enters PAUSED.
  - cpu_en is never high while cpu_rst is high.
- Request priority when pulses coincide: rst_req > run_toggle > step_req.
- rst_req in any state (including mid-RSTSEQ) restarts RSTSEQ with a full RST_CYCLES count.
- Any cpu_en pending in that cycle is dropped.
- PAUSED:
  - step_req -> STEP.
  - run_toggle -> RUN with divider=RUN_DIV-1.
- STEP:
  - cpu_en=1 for one cycle, then PAUSED.
  - Breakpoint, self-loop and memwrite checks are not applied.
- RUN:
  - Divider decrements each cycle. At 0: cpu_en=1 for the next cycle and divider reloads RUN_DIV-1.
  - step_req is ignored.
  - run_toggle -> PAUSED. If cpu_en is high in that same cycle, the instruction completes and is counted, but no halt checks are applied.
- Instruction capture:
  - The cycle cpu_en is high, the block latches pc_prev = pc and mw = memwrite.
  - The processor updates pc at the end of that cycle.
- Halt checks run in RUN, in the cycle after cpu_en, on the new pc. Priority order:
  1. bp_valid and pc == bp_pc -> HALT, cause 01.
  2. pc == pc_prev -> HALT, cause 10.
  3. Optional memwrite check (see Optional Feature).
- HALT:
  - halted=1 and cause is held; running=0.
  - step_req -> STEP, clears halted and cause.
  - run_toggle -> RUN, clears halted and cause.
- instr_count increments by 1 in every cpu_en cycle and saturates at all-ones.
- running and halted are registered and reflect the current state.

Optional Feature:
- Macro: EXEC_MEMWRITE_BREAK_EN.
- Defined: lowest-priority halt check, after breakpoint and self-loop. If mw was 1 for the retired instruction, RUN -> HALT with cause 11.
- Undefined: mw is not latched, memwrite is unused, and cause 11 is never produced.

Test Plan:
- Reset: hold reset=0, then release -> cpu_rst=1 for exactly 4 cycles, cpu_en=0 throughout, then PAUSED with instr_count=0.
- Step: three step_req pulses 10 cycles apart -> exactly three single-cycle cpu_en pulses, each 1 cycle after its request; instr_count=3; running=0.
- Run with breakpoint: bp_pc=0x0000000C, bp_valid=1, pc advances by 4 from 0 per cpu_en; run_toggle -> cpu_en every 4 cycles, halt after the 3rd instruction; halted=1, cause=01, instr_count=3.
- Self-loop: pc model holds at 0x00000020 after the instruction at 0x20 -> HALT with cause=10; then run_toggle -> RUN resumes and halts again after 1 instruction.
- Priority: rst_req, run_toggle and step_req in the same cycle during RUN -> RSTSEQ restarts, no cpu_en pulse, instr_count=0 and PAUSED after 4 cycles.
- With EXEC_MEMWRITE_BREAK_EN: memwrite=1 on the 2nd instruction in RUN -> HALT, cause=11, instr_count=2. Without the macro, same stimulus -> RUN continues.
